scr1_mem_arb: RTL
=================

SCR1_MEM_ARB -- requirements
Module: scr1_mem_arb

Interface
REQ-001 Parameter ARB_DEPTH, default 4, max outstanding accepted-but-unanswered requests; power of 2, >=2.
REQ-002 Parameter ADDR_WIDTH, default 32, address width on all ports.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  in  1  instruction read request.
REQ-006 imem_addr  in  ADDR_WIDTH  instruction address; word read implied.
REQ-007 imem_req_ack  out  1  imem request accepted this cycle.
REQ-008 imem_rdata  out  32  instruction read data.
REQ-009 imem_resp  out  2  type_scr1_mem_resp_e response to imem.
REQ-010 dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata  in  1/enum/enum/ADDR_WIDTH/32  data request bundle.
REQ-011 dmem_req_ack  out  1  dmem request accepted this cycle.
REQ-012 dmem_rdata  out  32; dmem_resp  out  2  data response.
REQ-013 mem_req, mem_cmd, mem_width, mem_addr, mem_wdata  out  1/enum/enum/ADDR_WIDTH/32  shared downstream request to the AXI memory bridge.
REQ-014 mem_req_ack  in  1; mem_rdata  in  32; mem_resp  in  2  downstream handshake and response.
REQ-015 arb_idle  out  1  no outstanding requests.
REQ-016 orphan_err  out  1  sticky: response arrived with no outstanding request.

Function
REQ-017 Request accept (handshake) defined as mem_req & mem_req_ack in same cycle; exactly one requester acked per accept.
REQ-018 mem_req = (imem_req | dmem_req) & ~full, combinational; full when occupancy == ARB_DEPTH.
REQ-019 Selection combinational, round-robin: if both request, grant the one not granted at last accept; single requester always granted.
REQ-020 Priority pointer updates only on accept; reset value favours dmem.
REQ-021 imem grant drives mem_cmd=RD, mem_width=WORD, mem_addr=imem_addr, mem_wdata=0; dmem grant passes dmem bundle unchanged.
REQ-022 imem_req_ack = mem_req_ack & grant==imem & ~full; dmem_req_ack likewise; never both high.
REQ-023 Grant decision not held across cycles: a requester not acked may change or drop its request.
REQ-024 Owner tag FIFO, depth ARB_DEPTH, 1-bit entries (0=imem, 1=dmem); push tag on accept.
REQ-025 Pop on mem_resp != NOTRDY while occupancy > 0; responses are in order.
REQ-026 Response routing combinational, zero latency: head tag's owner gets mem_resp and mem_rdata; other port sees resp=NOTRDY, rdata=0.
REQ-027 With occupancy 0, imem_resp = dmem_resp = NOTRDY regardless of mem_resp.
REQ-028 Both RDY_OK and RDY_ER pop the FIFO and are forwarded unchanged.
REQ-029 Simultaneous push and pop: occupancy unchanged, both pointers advance; at full, push blocked by REQ-018 even if pop occurs same cycle.
REQ-030 Pointers wrap modulo ARB_DEPTH; occupancy counter width clog2(ARB_DEPTH)+1, saturating impossible by construction.
REQ-031 Response with occupancy 0: no pop, no pointer change, orphan_err set to 1 until reset.
REQ-032 arb_idle = (occupancy == 0).

Reset
REQ-033 On rst_n low: occupancy 0, FIFO pointers 0, priority to dmem, orphan_err 0, arb_idle 1.
REQ-034 Reset mid-operation discards all outstanding tags; responses after reset count as orphans per REQ-031.
REQ-035 During reset all ack outputs 0 and all resp outputs NOTRDY.

Verification
REQ-036 Both requesters held high, mem_req_ack=1 always -> grants alternate dmem, imem, dmem, imem from reset; mem_req drops when occupancy reaches 4.
REQ-037 imem read 0x100 then dmem write 0x200 accepted; two RDY_OK responses -> first to imem with rdata 0xDEADBEEF, second to dmem; other port NOTRDY each cycle.
REQ-038 Occupancy 4, same cycle response pops and imem_req high -> no ack that cycle, ack next cycle, occupancy 4->3->4.
REQ-039 mem_resp=RDY_OK with no outstanding -> orphan_err=1, all resp outputs NOTRDY, arb_idle stays 1.
REQ-040 dmem read with mem_resp=RDY_ER -> dmem_resp=RDY_ER, tag popped, arb_idle returns to 1.
REQ-041 rst_n asserted with 3 outstanding -> arb_idle=1 immediately, next grant to dmem when both request.

Source files
------------

// File: rtl/scr1_mem_arb.sv
// Round-robin arbiter merging SCR1 imem and dmem request ports onto one memory port.
// An owner-tag FIFO routes the in-order responses back to the port that issued them.
package scr1_mem_arb_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

module scr1_mem_arb
   import scr1_mem_arb_pkg::*;
#(
   parameter int unsigned ARB_DEPTH  = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    imem_req,
   input  logic [ADDR_WIDTH-1:0]   imem_addr,
   output logic                    imem_req_ack,
   output logic [31:0]             imem_rdata,
   output type_scr1_mem_resp_e     imem_resp,
   input  logic                    dmem_req,
   input  type_scr1_mem_cmd_e      dmem_cmd,
   input  type_scr1_mem_width_e    dmem_width,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr,
   input  logic [31:0]             dmem_wdata,
   output logic                    dmem_req_ack,
   output logic [31:0]             dmem_rdata,
   output type_scr1_mem_resp_e     dmem_resp,
   output logic                    mem_req,
   output type_scr1_mem_cmd_e      mem_cmd,
   output type_scr1_mem_width_e    mem_width,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic                    mem_req_ack,
   input  logic [31:0]             mem_rdata,
   input  type_scr1_mem_resp_e     mem_resp,
   output logic                    arb_idle,
   output logic                    orphan_err
);
   localparam int unsigned PW = $clog2(ARB_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(ARB_DEPTH);

   logic [ARB_DEPTH-1:0] tags_q, tags_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 prio_dmem_q, prio_dmem_d;
   logic                 orphan_q, orphan_d;

   logic full, sel_dmem, accept, resp_vld, pop, head_dmem, busy;

   always_comb begin
      full     = (cnt_q == DEPTH_C);
      busy     = (cnt_q != '0);
      // Gating with rst_n keeps acks low while reset is held, even if the bridge acks.
      mem_req  = rst_n & (imem_req | dmem_req) & ~full;
      sel_dmem = dmem_req & (~imem_req | prio_dmem_q);
      accept   = mem_req & mem_req_ack;
      imem_req_ack = accept & ~sel_dmem;
      dmem_req_ack = accept &  sel_dmem;

      if (sel_dmem) begin
         mem_cmd   = dmem_cmd;
         mem_width = dmem_width;
         mem_addr  = dmem_addr;
         mem_wdata = dmem_wdata;
      end else begin
         mem_cmd   = SCR1_MEM_CMD_RD;
         mem_width = SCR1_MEM_WIDTH_WORD;
         mem_addr  = imem_addr;
         mem_wdata = '0;
      end

      resp_vld  = (mem_resp != SCR1_MEM_RESP_NOTRDY);
      pop       = resp_vld & busy;
      head_dmem = tags_q[rd_ptr_q];

      imem_resp  = SCR1_MEM_RESP_NOTRDY;
      imem_rdata = '0;
      dmem_resp  = SCR1_MEM_RESP_NOTRDY;
      dmem_rdata = '0;
      if (busy) begin
         if (head_dmem) begin
            dmem_resp  = mem_resp;
            dmem_rdata = mem_rdata;
         end else begin
            imem_resp  = mem_resp;
            imem_rdata = mem_rdata;
         end
      end

      tags_d      = tags_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      prio_dmem_d = prio_dmem_q;
      orphan_d    = orphan_q | (resp_vld & ~busy);
      if (accept) begin
         tags_d[wr_ptr_q] = sel_dmem;
         wr_ptr_d         = wr_ptr_q + PW'(1);
         prio_dmem_d      = ~sel_dmem;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      arb_idle   = ~busy;
      orphan_err = orphan_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         prio_dmem_q <= 1'b1;
         orphan_q    <= 1'b0;
      end else begin
         tags_q      <= tags_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         prio_dmem_q <= prio_dmem_d;
         orphan_q    <= orphan_d;
      end
   end
endmodule
